// File: rtl/hps_button_debounce_if.sv
// Bundles the raw button pins with the debounced level and event strobes.
// master: pad/board side that drives the raw pins and consumes the results.
// slave : the debounce block.
interface hps_button_debounce_if #(
  parameter int NUM_BUTTONS = 4
);
  logic [NUM_BUTTONS-1:0] button_raw;
  logic [NUM_BUTTONS-1:0] btn_level;
  logic [NUM_BUTTONS-1:0] press_pulse;
  logic [NUM_BUTTONS-1:0] release_pulse;
  logic [NUM_BUTTONS-1:0] repeat_pulse;

  modport master (
    output button_raw,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  repeat_pulse
  );

  modport slave (
    input  button_raw,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output repeat_pulse
  );
endinterface

// File: rtl/hps_button_debounce.sv
// Push-button conditioner for the HPS button PIOs.
// Each channel: 2-flop synchroniser, debounce counter, 4-state FSM, and
// registered press/release/auto-repeat single-cycle strobes.
module hps_button_debounce #(
  parameter int NUM_BUTTONS     = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter int REPEAT_EN       = 1
) (
  input logic                 clk,
  input logic                 reset_n,
  hps_button_debounce_if.slave bus
);

  localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HT_W     = $clog2(HOLD_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HT_W-1:0] HOLD_LAST = HT_W'(HOLD_CYCLES - 1);
  localparam logic [HT_W-1:0] REP_LAST  = HT_W'(REPEAT_CYCLES - 1);
  localparam logic            POL       = (ACTIVE_LOW != 0);
  localparam logic            USE_REP   = (REPEAT_EN != 0);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [NUM_BUTTONS-1:0] sync1;
  logic [NUM_BUTTONS-1:0] sync2;
  logic [NUM_BUTTONS-1:0] level_q;
  logic [NUM_BUTTONS-1:0] press_q;
  logic [NUM_BUTTONS-1:0] release_q;
  logic [NUM_BUTTONS-1:0] repeat_q;

  // Two-flop synchroniser; resets to the unpressed pin level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= {NUM_BUTTONS{POL}};
      sync2 <= {NUM_BUTTONS{POL}};
    end else begin
      sync1 <= bus.button_raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    state_t          state;
    logic [DB_W-1:0] db_cnt;
    logic [HT_W-1:0] hold_cnt;
    logic            repeating;
    logic            lvl;
    logic            prs;
    logic            rel;
    logic            rpt;
    logic            pressed_s;

    assign pressed_s = sync2[i] ^ POL;

    // Per-channel debounce FSM with hold/auto-repeat timer; all outputs registered.
    // db_cnt already counts the current stable sample, so a change is accepted
    // on the edge where db_cnt reaches DEBOUNCE_CYCLES-1 and the sample still agrees.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state     <= RELEASED;
        db_cnt    <= '0;
        hold_cnt  <= '0;
        repeating <= 1'b0;
        lvl       <= 1'b0;
        prs       <= 1'b0;
        rel       <= 1'b0;
        rpt       <= 1'b0;
      end else begin
        prs <= 1'b0;
        rel <= 1'b0;
        rpt <= 1'b0;
        case (state)
          RELEASED: begin
            if (pressed_s) begin
              state  <= PRESS_WAIT;
              db_cnt <= DB_W'(1);
            end
          end
          PRESS_WAIT: begin
            if (!pressed_s) begin
              state  <= RELEASED;
              db_cnt <= '0;
            end else if (db_cnt >= DB_LAST) begin
              state     <= PRESSED;
              db_cnt    <= '0;
              hold_cnt  <= '0;
              repeating <= 1'b0;
              lvl       <= 1'b1;
              prs       <= 1'b1;
            end else begin
              db_cnt <= db_cnt + DB_W'(1);
            end
          end
          PRESSED: begin
            if (!pressed_s) begin
              // Leaving PRESSED takes priority over a due repeat strobe.
              state  <= RELEASE_WAIT;
              db_cnt <= DB_W'(1);
            end else if (USE_REP) begin
              if (hold_cnt >= (repeating ? REP_LAST : HOLD_LAST)) begin
                rpt       <= 1'b1;
                hold_cnt  <= '0;
                repeating <= 1'b1;
              end else begin
                hold_cnt <= hold_cnt + HT_W'(1);
              end
            end
          end
          RELEASE_WAIT: begin
            if (pressed_s) begin
              state     <= PRESSED;
              db_cnt    <= '0;
              hold_cnt  <= '0;
              repeating <= 1'b0;
            end else if (db_cnt >= DB_LAST) begin
              state  <= RELEASED;
              db_cnt <= '0;
              lvl    <= 1'b0;
              rel    <= 1'b1;
            end else begin
              db_cnt <= db_cnt + DB_W'(1);
            end
          end
          default: begin
            state  <= RELEASED;
            db_cnt <= '0;
          end
        endcase
      end
    end

    assign level_q[i]   = lvl;
    assign press_q[i]   = prs;
    assign release_q[i] = rel;
    assign repeat_q[i]  = rpt;
  end

  assign bus.btn_level     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.repeat_pulse  = repeat_q;

endmodule
